mod_exp_engine: RTL and testbench
=================================

MOD_EXP_ENGINE -- requirements
Module: mod_exp_engine

Interface
REQ-001 Parameter: W, default 32, operand width in bits; the result bus is 2*W.
REQ-002 clk  input  1  clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 g  input  W  base (generator or peer public value).
REQ-006 x  input  W  exponent (private key).
REQ-007 p  input  W  modulus.
REQ-008 exp  output  2*W  result g^x mod p, zero-extended; feeds the downstream key/encryption stage's exp input.
REQ-009 done_i_enc2  output  1  one-cycle pulse marking exp valid; drives the downstream stage's enable of the same name.
REQ-010 busy  output  1  high from the cycle after start is accepted through the done cycle.
REQ-011 err  output  1  set with done_i_enc2 when p==0; held until the next accepted start.

Function
REQ-012 Inputs g, x, p are captured on the start edge; later input changes have no effect on the current operation.
REQ-013 States: IDLE, RBASE, MULA, REDA, MULB, REDB, FIN.
REQ-014 IDLE & start & p!=0 -> RBASE; IDLE & start & p==0 -> FIN with err=1 and exp=0.
REQ-015 RBASE: base = g mod p, computed bit-serially (restoring shift-subtract, one dividend bit per cycle); takes exactly 2*W cycles.
REQ-016 Initial values: acc=1 mod p (0 if p==1), bit index i=0.
REQ-017 MULA (1 cycle): prod = acc * (x[i] ? base : 1), full 2*W product.
REQ-018 REDA (2*W cycles): acc = prod mod p.
REQ-019 MULB (1 cycle): prod = base*base.
REQ-020 REDB (2*W cycles): base = prod mod p; i++; if i==W -> FIN, else -> MULA.
REQ-021 All W exponent bits are always processed, and multiply-by-1 is still reduced; latency is data-independent.
REQ-022 Latency: start high in cycle N -> done_i_enc2 high in cycle N+1+2W+W*(4W+2); this is N+4225 for W=32. The p==0 path gives done in cycle N+1.
REQ-023 FIN (1 cycle): exp <= {W'b0, acc}; done_i_enc2=1 for this cycle only; next state IDLE.
REQ-024 exp holds its value until the next FIN; it is unchanged while busy.
REQ-025 start while busy or in FIN is ignored; it is not queued.
REQ-026 start in the same cycle as the return to IDLE is accepted only if IDLE is already the current state.
REQ-027 Reduction invariant: every intermediate acc and base is < p; all multiplier operands are W bits, so no overflow of the 2*W product.
REQ-028 p==1 yields exp=0; x==0 yields exp=1 mod p.

Reset
REQ-029 rst=1 at a clock edge: state=IDLE, exp=0, done_i_enc2=0, busy=0, err=0, internal acc/base/prod/index cleared.
REQ-030 rst asserted mid-operation aborts the operation with no done pulse; the first start after rst deasserts is accepted normally.
REQ-031 rst has priority over start in the same cycle.

Verification
REQ-032 g=5, x=6, p=23, start at cycle N -> done at N+4225, exp=8, err=0; busy high N+1..N+4225.
REQ-033 g=5, x=3, p=23, then with busy high pulse start with g=2, x=5, p=7 -> ignored; exp=10 with exactly one done pulse.
REQ-034 x=0, g=9, p=11 -> exp=1; p=1, g=9, x=7 -> exp=0, with the same latency.
REQ-035 p=0 -> done at N+1, err=1, exp=0; next start with p=23, g=5, x=6 -> err cleared at accept, exp=8.
REQ-036 rst pulsed at N+2000 of an operation -> no done pulse, all outputs 0; restart with g=3, x=0xFFFFFFFF, p=0xFFFFFFFB -> exp matches the reference model.
REQ-037 Back-to-back: start asserted in the cycle after done -> accepted; the second result is correct with identical latency.

Source files
------------

// File: rtl/mod_exp_engine.sv
`timescale 1ns/1ps
// mod_exp_engine
// Modular exponentiation g^x mod p with a data-independent latency.
// Right-to-left square-and-multiply: every exponent bit costs one multiply
// (by base or by 1), one reduction, one squaring and one reduction.
// Reductions use a single bit-serial restoring shift-subtract unit that
// consumes one dividend bit per cycle over a 2*W-bit dividend.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   start        request pulse, sampled only in IDLE
//   g, x, p      base, exponent, modulus (captured when start is accepted)
//   exp          result g^x mod p, zero-extended to 2*W bits
//   done_i_enc2  one-cycle pulse marking exp valid
//   busy         high from the cycle after accept through the done cycle
//   err          set with done when p==0, held until the next accepted start
module mod_exp_engine #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   g,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   p,
  output logic [2*W-1:0] exp,
  output logic           done_i_enc2,
  output logic           busy,
  output logic           err
);

  localparam int CW = $clog2(2*W);
  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(2*W-1);
  localparam logic [IW-1:0] IDX_LAST = IW'(W-1);

  typedef enum logic [2:0] {
    IDLE, RBASE, MULA, REDA, MULB, REDB, FIN
  } state_t;

  state_t state, state_next;

  logic [W-1:0]   x_r, p_r;
  logic [W-1:0]   acc, base;
  logic [2*W-1:0] prod;
  logic [W-1:0]   rem;
  logic [CW-1:0]  cnt;
  logic [IW-1:0]  idx;

  logic           cnt_last, idx_last;
  logic [W:0]     rem_shift;
  logic           rem_ge;
  logic [W-1:0]   rem_next;
  logic [W-1:0]   mul_op;

  assign cnt_last = (cnt == CNT_LAST);
  assign idx_last = (idx == IDX_LAST);

  // One restoring division step: shift in the next dividend bit and subtract
  // p when possible. rem stays below p, so the result always fits W bits.
  assign rem_shift = {rem, prod[2*W-1]};
  assign rem_ge    = (rem_shift >= {1'b0, p_r});
  assign rem_next  = rem_ge ? W'(rem_shift - {1'b0, p_r}) : rem_shift[W-1:0];

  // Multiply by 1 for clear exponent bits keeps the latency data-independent.
  assign mul_op = x_r[idx] ? base : W'(1);

  assign done_i_enc2 = (state == FIN);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = (p == '0) ? FIN : RBASE;
      RBASE: if (cnt_last) state_next = MULA;
      MULA:  state_next = REDA;
      REDA:  if (cnt_last) state_next = MULB;
      MULB:  state_next = REDB;
      REDB:  if (cnt_last) state_next = idx_last ? FIN : MULA;
      FIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath. The final acc is loaded into exp on the edge entering FIN so
  // that exp is already valid while done_i_enc2 is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r  <= '0;
      p_r  <= '0;
      acc  <= '0;
      base <= '0;
      prod <= '0;
      rem  <= '0;
      cnt  <= '0;
      idx  <= '0;
      exp  <= '0;
      err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x_r  <= x;
            p_r  <= p;
            prod <= {{W{1'b0}}, g};
            rem  <= '0;
            cnt  <= '0;
            idx  <= '0;
            base <= '0;
            acc  <= (p == W'(1)) ? W'(0) : W'(1);
            err  <= (p == '0);
            if (p == '0) exp <= '0;
          end
        end
        RBASE, REDA, REDB: begin
          prod <= {prod[2*W-2:0], 1'b0};
          rem  <= rem_next;
          cnt  <= cnt_last ? '0 : cnt + CW'(1);
          if (cnt_last) begin
            if (state == REDA) begin
              acc <= rem_next;
            end else begin
              base <= rem_next;
            end
            if (state == REDB) begin
              idx <= idx + IW'(1);
              if (idx_last) exp <= {{W{1'b0}}, acc};
            end
          end
        end
        MULA: begin
          prod <= (2*W)'(acc) * (2*W)'(mul_op);
          rem  <= '0;
          cnt  <= '0;
        end
        MULB: begin
          prod <= (2*W)'(base) * (2*W)'(base);
          rem  <= '0;
          cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_engine.sv
`timescale 1ns/1ps
// tb_mod_exp_engine
// Directed testbench for mod_exp_engine with hand-computed results.
// Expected values:
//   5^6 mod 23 = 8, 5^3 mod 23 = 10, 9^0 mod 11 = 1, 9^7 mod 1 = 0,
//   3^(2^32-1) mod (2^32-5) = 3^5 = 243 (prime modulus, Fermat),
//   7^10 mod 13 = 4, 2^32 mod (2^32-5) = 5, 30^1 mod 23 = 7.
module tb_mod_exp_engine;

  localparam int W   = 32;
  localparam int LAT = 1 + 2*W + W*(4*W+2);

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   g, x, p;
  logic [2*W-1:0] exp_out;
  logic           done_i_enc2, busy, err;

  int checks = 0;
  int errors = 0;

  int          lat, pulses, busy_low;
  logic [63:0] res_exp, snap_exp;
  logic        res_err, busy_after, err_at1;
  logic [2:0]  snap_flags;

  always #5 clk = ~clk;

  mod_exp_engine #(.W(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .g(g),
    .x(x),
    .p(p),
    .exp(exp_out),
    .done_i_enc2(done_i_enc2),
    .busy(busy),
    .err(err)
  );

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Starts one operation and watches it cycle by cycle; k counts cycles after
  // the start cycle. Optionally injects a second start while busy or a reset.
  // Returns at the negedge of cycle lat+extra (extra=0 leaves us in the done
  // cycle so the next call starts in the very next cycle).
  task automatic apply_stimulus(input logic [W-1:0] gv, xv, pv, input int extra,
                                input int inject_at, input int rst_at);
    @(negedge clk);
    g = gv; x = xv; p = pv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1; pulses = 0; busy_low = 0; busy_after = 1'b1; err_at1 = 1'bx;
    res_exp = '1; res_err = 1'bx; snap_exp = '1; snap_flags = '1;
    for (int k = 1; k <= LAT + 200; k++) begin
      if (k == 1) err_at1 = err;
      if (k == inject_at) begin
        g = 2; x = 5; p = 7; start = 1'b1;
      end else if (k == inject_at + 1) begin
        start = 1'b0;
      end
      if (k == rst_at) begin
        rst = 1'b1;
      end else if (k == rst_at + 1) begin
        rst = 1'b0;
        snap_exp = exp_out;
        snap_flags = {done_i_enc2, busy, err};
      end
      if (done_i_enc2) begin
        pulses++;
        if (lat < 0) begin
          lat = k; res_exp = exp_out; res_err = err;
        end
      end
      if (lat < 0 && !busy) busy_low++;
      if (lat >= 0 && k == lat + 1) busy_after = busy;
      if (lat >= 0 && k >= lat + extra) break;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; g = '0; x = '0; p = '0;
    repeat (3) @(negedge clk);
    check_output("reset_exp",  exp_out, 64'd0);
    check_output("reset_done", 64'(done_i_enc2), 64'd0);
    check_output("reset_busy", 64'(busy), 64'd0);
    check_output("reset_err",  64'(err), 64'd0);
    rst = 1'b0;

    $display("[TB] 5^6 mod 23");
    apply_stimulus(32'd5, 32'd6, 32'd23, 3, -10, -10);
    check_output("op1_latency",    64'(lat), 64'(LAT));
    check_output("op1_exp",        res_exp, 64'd8);
    check_output("op1_err",        64'(res_err), 64'd0);
    check_output("op1_pulses",     64'(pulses), 64'd1);
    check_output("op1_busy_gaps",  64'(busy_low), 64'd0);
    check_output("op1_busy_after", 64'(busy_after), 64'd0);

    $display("[TB] 5^3 mod 23 with ignored start while busy");
    apply_stimulus(32'd5, 32'd3, 32'd23, 3, 100, -10);
    check_output("ignored_latency", 64'(lat), 64'(LAT));
    check_output("ignored_exp",     res_exp, 64'd10);
    check_output("ignored_pulses",  64'(pulses), 64'd1);

    $display("[TB] x=0 and p=1 corner cases");
    apply_stimulus(32'd9, 32'd0, 32'd11, 3, -10, -10);
    check_output("x0_latency", 64'(lat), 64'(LAT));
    check_output("x0_exp",     res_exp, 64'd1);
    apply_stimulus(32'd9, 32'd7, 32'd1, 3, -10, -10);
    check_output("p1_latency", 64'(lat), 64'(LAT));
    check_output("p1_exp",     res_exp, 64'd0);

    $display("[TB] p=0 error path");
    apply_stimulus(32'd5, 32'd6, 32'd0, 3, -10, -10);
    check_output("p0_latency",    64'(lat), 64'd1);
    check_output("p0_err",        64'(res_err), 64'd1);
    check_output("p0_exp",        res_exp, 64'd0);
    check_output("p0_err_held",   64'(err), 64'd1);
    apply_stimulus(32'd5, 32'd6, 32'd23, 3, -10, -10);
    check_output("after_p0_err_at_accept", 64'(err_at1), 64'd0);
    check_output("after_p0_exp",           res_exp, 64'd8);
    check_output("after_p0_err",           64'(res_err), 64'd0);

    $display("[TB] reset mid-operation");
    apply_stimulus(32'd5, 32'd6, 32'd23, 3, -10, 2000);
    check_output("midrst_pulses", 64'(pulses), 64'd0);
    check_output("midrst_exp",    snap_exp, 64'd0);
    check_output("midrst_flags",  64'(snap_flags), 64'd0);
    apply_stimulus(32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 3, -10, -10);
    check_output("restart_latency", 64'(lat), 64'(LAT));
    check_output("restart_exp",     res_exp, 64'd243);

    $display("[TB] back-to-back operations");
    apply_stimulus(32'd7, 32'd10, 32'd13, 0, -10, -10);
    check_output("b2b_first_exp", res_exp, 64'd4);
    apply_stimulus(32'd2, 32'd32, 32'hFFFF_FFFB, 3, -10, -10);
    check_output("b2b_second_latency", 64'(lat), 64'(LAT));
    check_output("b2b_second_exp",     res_exp, 64'd5);

    $display("[TB] base larger than modulus");
    apply_stimulus(32'd30, 32'd1, 32'd23, 3, -10, -10);
    check_output("gbig_exp", res_exp, 64'd7);

    $display("[TB] reset has priority over start");
    @(negedge clk);
    g = 32'd5; x = 32'd6; p = 32'd23; rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check_output("rst_prio_busy", 64'(busy), 64'd0);
    check_output("rst_prio_exp",  exp_out, 64'd0);
    @(negedge clk);
    check_output("rst_prio_busy_later", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
